// File: rtl/phase_window_decimator.sv
`default_nettype none
// ============================================================================
// Module      : phase_window_decimator
// Description : Mean phase and net phase advance over 2^k-sample windows of
//               an unwrapped 11Q21 phase stream, delivered on an AXIS master.
// Revision    : 1.0
// ============================================================================
module phase_window_decimator #(
    parameter int S_AXIS_TDATA_WIDTH = 32,
    parameter int M_AXIS_TDATA_WIDTH = 64,
    parameter int ACC_WIDTH          = 48,
    parameter int MAX_DECIM_LOG2     = 16
) (
    input  logic                          aclk,
    input  logic                          areset,
    input  logic [S_AXIS_TDATA_WIDTH-1:0] S_AXIS_tdata,
    input  logic                          S_AXIS_tvalid,
    input  logic                          enable,
    input  logic [4:0]                    decim_log2,
    output logic [M_AXIS_TDATA_WIDTH-1:0] M_AXIS_tdata,
    output logic                          M_AXIS_tvalid,
    input  logic                          M_AXIS_tready,
    output logic                          overrun,
    output logic [15:0]                   window_count
);

    localparam int DW = S_AXIS_TDATA_WIDTH;
    localparam int CW = MAX_DECIM_LOG2 + 1;

    localparam logic [4:0] c_KMAX  = 5'(MAX_DECIM_LOG2);
    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_PRIME = 2'd1;
    localparam logic [1:0] c_ACCUM = 2'd2;

    logic [1:0]           state_q, state_d;
    logic [ACC_WIDTH-1:0] sum_q;
    logic [CW-1:0]        cnt_q;
    logic [DW-1:0]        pref_q;
    logic [4:0]           k_q;

    logic                 strb1_q;
    logic [ACC_WIDTH-1:0] wsum1_q;
    logic [DW-1:0]        delta1_q;
    logic [4:0]           shift1_q;

    logic                 res_vld_q;
    logic [DW-1:0]        res_mean_q;
    logic [DW-1:0]        res_delta_q;

    logic [M_AXIS_TDATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                          out_vld_q, out_vld_d;
    logic                          overrun_q, overrun_d;
    logic [15:0]                   wcount_q, wcount_d;

    logic                        w_prime_take;
    logic                        w_accum_take;
    logic                        w_win_end;
    logic [4:0]                  w_k_clamped;
    logic [ACC_WIDTH-1:0]        w_sample_ext;
    logic [ACC_WIDTH-1:0]        w_sum_full;
    logic [CW-1:0]               w_last_cnt;
    logic [DW-1:0]               w_delta;
    logic signed [ACC_WIDTH-1:0] w_mean_full;

    assign w_k_clamped  = (decim_log2 > c_KMAX) ? c_KMAX : decim_log2;
    assign w_sample_ext = {{(ACC_WIDTH-DW){S_AXIS_tdata[DW-1]}}, S_AXIS_tdata};
    assign w_sum_full   = sum_q + w_sample_ext;
    assign w_last_cnt   = (CW'(1) << k_q) - CW'(1);
    assign w_delta      = S_AXIS_tdata - pref_q;
    assign w_mean_full  = $signed(wsum1_q) >>> shift1_q;

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q <= c_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            c_IDLE:  if (enable) state_d = c_PRIME;
            c_PRIME: begin
                if (!enable)            state_d = c_IDLE;
                else if (S_AXIS_tvalid) state_d = c_ACCUM;
            end
            c_ACCUM: if (!enable) state_d = c_IDLE;
            default: state_d = c_IDLE;
        endcase
    end

    always_comb begin
        w_prime_take = 1'b0;
        w_accum_take = 1'b0;
        case (state_q)
            c_PRIME: w_prime_take = enable && S_AXIS_tvalid;
            c_ACCUM: w_accum_take = enable && S_AXIS_tvalid;
            default: ;
        endcase
        w_win_end = w_accum_take && (cnt_q == w_last_cnt);
    end

    // ------------------------------------------------------------------
    // Window accumulation
    // ------------------------------------------------------------------
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            sum_q  <= '0;
            cnt_q  <= '0;
            pref_q <= '0;
            k_q    <= '0;
        end else if (!enable) begin
            sum_q <= '0;
            cnt_q <= '0;
        end else if (w_prime_take || w_win_end) begin
            // The closing sample of one window is the reference of the next.
            pref_q <= S_AXIS_tdata;
            k_q    <= w_k_clamped;
            sum_q  <= '0;
            cnt_q  <= '0;
        end else if (w_accum_take) begin
            sum_q <= w_sum_full;
            cnt_q <= cnt_q + CW'(1);
        end
    end

    // ------------------------------------------------------------------
    // Result pipeline: strobe stage, then shift stage
    // ------------------------------------------------------------------
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            strb1_q     <= 1'b0;
            wsum1_q     <= '0;
            delta1_q    <= '0;
            shift1_q    <= '0;
            res_vld_q   <= 1'b0;
            res_mean_q  <= '0;
            res_delta_q <= '0;
        end else begin
            strb1_q <= w_win_end;
            if (w_win_end) begin
                wsum1_q  <= w_sum_full;
                delta1_q <= w_delta;
                shift1_q <= k_q;
            end
            res_vld_q <= strb1_q;
            if (strb1_q) begin
                res_mean_q  <= w_mean_full[DW-1:0];
                res_delta_q <= delta1_q;
            end
        end
    end

    // ------------------------------------------------------------------
    // AXIS output register
    // ------------------------------------------------------------------
    always_comb begin
        out_data_d = out_data_q;
        out_vld_d  = out_vld_q;
        overrun_d  = overrun_q;
        wcount_d   = wcount_q;
        if (out_vld_q && M_AXIS_tready) out_vld_d = 1'b0;
        if (!enable) overrun_d = 1'b0;
        if (res_vld_q) begin
            wcount_d = wcount_q + 16'd1;
            // A full register that is not draining this cycle loses the new result.
            if (out_vld_q && !M_AXIS_tready) begin
                overrun_d = 1'b1;
            end else begin
                out_data_d = {res_mean_q, res_delta_q};
                out_vld_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            out_data_q <= '0;
            out_vld_q  <= 1'b0;
            overrun_q  <= 1'b0;
            wcount_q   <= '0;
        end else begin
            out_data_q <= out_data_d;
            out_vld_q  <= out_vld_d;
            overrun_q  <= overrun_d;
            wcount_q   <= wcount_d;
        end
    end

    assign M_AXIS_tdata  = out_data_q;
    assign M_AXIS_tvalid = out_vld_q;
    assign overrun       = overrun_q;
    assign window_count  = wcount_q;

endmodule
`default_nettype wire

// File: tb/tb_phase_window_decimator.sv
`default_nettype none
// ============================================================================
// Module      : tb_phase_window_decimator
// Description : Self-checking bench for phase_window_decimator.
// Revision    : 1.0
// ============================================================================
module tb_phase_window_decimator;

    logic        aclk = 1'b0;
    logic        areset;
    logic [31:0] s_tdata;
    logic        s_tvalid;
    logic        enable;
    logic [4:0]  decim;
    logic [63:0] m_tdata;
    logic        m_tvalid;
    logic        m_tready;
    logic        ovr;
    logic [15:0] wc;

    always #5 aclk = ~aclk;

    phase_window_decimator dut (
        .aclk          (aclk),
        .areset        (areset),
        .S_AXIS_tdata  (s_tdata),
        .S_AXIS_tvalid (s_tvalid),
        .enable        (enable),
        .decim_log2    (decim),
        .M_AXIS_tdata  (m_tdata),
        .M_AXIS_tvalid (m_tvalid),
        .M_AXIS_tready (m_tready),
        .overrun       (ovr),
        .window_count  (wc)
    );

    int n_checks = 0;
    int n_err    = 0;

    logic [63:0] obs_q[$];
    logic [63:0] exp_q[$];

    // Reference model state: collects whole windows of samples
    bit          m_primed;
    logic [31:0] m_pref;
    int          m_k;
    longint      m_sum;
    int          m_n;

    always @(negedge aclk)
        if (!areset && m_tvalid && m_tready) obs_q.push_back(m_tdata);

    function automatic int clampk(logic [4:0] d);
        return (int'(d) > 16) ? 16 : int'(d);
    endfunction

    task automatic model_reset();
        m_primed = 1'b0;
        m_sum    = 0;
        m_n      = 0;
    endtask

    task automatic model_push(logic [31:0] s, logic [4:0] d);
        longint      mean;
        logic [31:0] delta;
        if (!m_primed) begin
            m_primed = 1'b1;
            m_pref   = s;
            m_k      = clampk(d);
            m_sum    = 0;
            m_n      = 0;
        end else begin
            m_sum += longint'($signed(s));
            m_n++;
            if (m_n == (1 << m_k)) begin
                mean  = m_sum >>> m_k;
                delta = s - m_pref;
                exp_q.push_back({mean[31:0], delta});
                m_pref = s;
                m_sum  = 0;
                m_n    = 0;
                m_k    = clampk(d);
            end
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic send(logic [31:0] s);
        s_tdata  = s;
        s_tvalid = 1'b1;
        @(posedge aclk);
        #1;
        s_tvalid = 1'b0;
        model_push(s, decim);
    endtask

    task automatic restart(logic [4:0] k);
        enable = 1'b0;
        tick();
        decim  = k;
        enable = 1'b1;
        tick();
        model_reset();
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset();
        areset = 1'b1;
        repeat (2) @(posedge aclk);
        #1;
        n_checks++; if (m_tdata !== 64'd0) begin n_err++; $display("FAIL reset_tdata got %h want 0", m_tdata); end
        n_checks++; if (m_tvalid !== 1'b0) begin n_err++; $display("FAIL reset_tvalid got %b want 0", m_tvalid); end
        n_checks++; if (ovr !== 1'b0) begin n_err++; $display("FAIL reset_overrun got %b want 0", ovr); end
        n_checks++; if (wc !== 16'd0) begin n_err++; $display("FAIL reset_wcount got %0d want 0", wc); end
        @(negedge aclk);
        areset = 1'b0;
        tick();
    endtask

    task automatic test_ramp();
        m_tready = 1'b1;
        restart(5'd2);
        for (int i = 0; i <= 4; i++) send(32'(i * 1000));
        @(negedge aclk);
        n_checks++; if (m_tvalid !== 1'b0) begin n_err++; $display("FAIL ramp_lat0 got %b want 0", m_tvalid); end
        tick();
        @(negedge aclk);
        n_checks++; if (m_tvalid !== 1'b0) begin n_err++; $display("FAIL ramp_lat1 got %b want 0", m_tvalid); end
        tick();
        @(negedge aclk);
        n_checks++; if (m_tvalid !== 1'b1 || m_tdata !== {32'd2500, 32'd4000}) begin
            n_err++; $display("FAIL ramp_lat2 got v=%b %h want v=1 %h", m_tvalid, m_tdata, {32'd2500, 32'd4000});
        end
        for (int i = 5; i <= 8; i++) send(32'(i * 1000));
        repeat (4) tick();
        n_checks++; if (obs_q.size() != 2) begin n_err++; $display("FAIL ramp_count got %0d want 2", obs_q.size()); end
        else begin
            n_checks++; if (obs_q[1] !== {32'd6500, 32'd4000}) begin n_err++; $display("FAIL ramp_res2 got %h want %h", obs_q[1], {32'd6500, 32'd4000}); end
        end
        n_checks++; if (wc !== 16'd2) begin n_err++; $display("FAIL ramp_wcount got %0d want 2", wc); end
    endtask

    task automatic test_floor();
        restart(5'd1);
        send(32'd0);
        send(-32'sd3); send(-32'sd3); send(-32'sd5); send(-32'sd4);
        repeat (4) tick();
        n_checks++; if (obs_q.size() != 2) begin n_err++; $display("FAIL floor_count got %0d want 2", obs_q.size()); end
        else begin
            n_checks++; if (obs_q[0] !== {32'hFFFF_FFFD, 32'hFFFF_FFFD}) begin n_err++; $display("FAIL floor_res1 got %h want fffffffdfffffffd", obs_q[0]); end
            n_checks++; if (obs_q[1] !== {32'hFFFF_FFFB, 32'hFFFF_FFFF}) begin n_err++; $display("FAIL floor_res2 got %h want fffffffbffffffff", obs_q[1]); end
        end
    endtask

    task automatic test_delta_wrap();
        restart(5'd0);
        send(32'h7FFF_FFF0);
        send(32'h8000_0010);
        repeat (4) tick();
        n_checks++; if (obs_q.size() != 1 || obs_q[0] !== {32'h8000_0010, 32'h0000_0020}) begin
            n_err++; $display("FAIL delta_wrap got n=%0d %h want 8000001000000020", obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : 64'd0);
        end
    endtask

    task automatic test_back_pressure();
        logic [15:0] wc0;
        restart(5'd0);
        m_tready = 1'b0;
        wc0 = wc;
        send(32'd100); send(32'd150); send(32'd170); send(32'd200);
        repeat (3) tick();
        n_checks++; if (ovr !== 1'b1) begin n_err++; $display("FAIL bp_overrun got %b want 1", ovr); end
        n_checks++; if (wc !== 16'(wc0 + 16'd3)) begin n_err++; $display("FAIL bp_wcount got %0d want %0d", wc, 16'(wc0 + 16'd3)); end
        for (int i = 0; i < 3; i++) begin
            @(negedge aclk);
            n_checks++; if (m_tvalid !== 1'b1 || m_tdata !== {32'd150, 32'd50}) begin
                n_err++; $display("FAIL bp_hold got v=%b %h want v=1 %h", m_tvalid, m_tdata, {32'd150, 32'd50});
            end
            tick();
        end
        m_tready = 1'b1;
        tick();
        @(negedge aclk);
        n_checks++; if (m_tvalid !== 1'b0) begin n_err++; $display("FAIL bp_drain got %b want 0", m_tvalid); end
        n_checks++; if (obs_q.size() != 1 || obs_q[0] !== {32'd150, 32'd50}) begin
            n_err++; $display("FAIL bp_xfer got n=%0d want 1 transfer of %h", obs_q.size(), {32'd150, 32'd50});
        end
        enable = 1'b0;
        tick();
        n_checks++; if (ovr !== 1'b0) begin n_err++; $display("FAIL bp_ovr_clear got %b want 0", ovr); end
    endtask

    task automatic test_clamp_kchange();
        restart(5'd31);
        send($urandom);
        for (int i = 0; i < 65535; i++) begin
            if (i == 100) decim = 5'd1;
            send($urandom);
        end
        repeat (3) tick();
        n_checks++; if (m_tvalid !== 1'b0) begin n_err++; $display("FAIL clamp_early got %b want 0", m_tvalid); end
        send($urandom);
        send($urandom); send($urandom);
        repeat (4) tick();
        n_checks++; if (obs_q.size() != 2 || exp_q.size() != 2) begin
            n_err++; $display("FAIL clamp_count got %0d want 2 (model %0d)", obs_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < 2; i++) begin
                n_checks++; if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL clamp_res%0d got %h want %h", i, obs_q[i], exp_q[i]); end
            end
        end
    endtask

    task automatic test_reset_disable_mid();
        restart(5'd2);
        m_tready = 1'b0;
        for (int i = 0; i < 5; i++) send(32'(i * 7));
        repeat (3) tick();
        send(32'd55); send(32'd66);
        n_checks++; if (m_tvalid !== 1'b1) begin n_err++; $display("FAIL rmid_pre got %b want 1", m_tvalid); end
        #2 areset = 1'b1;
        #1;
        n_checks++; if (m_tdata !== 64'd0 || m_tvalid !== 1'b0 || ovr !== 1'b0 || wc !== 16'd0) begin
            n_err++; $display("FAIL rmid_async got %h v=%b o=%b wc=%0d want all 0", m_tdata, m_tvalid, ovr, wc);
        end
        @(negedge aclk);
        areset   = 1'b0;
        m_tready = 1'b1;
        tick();
        restart(5'd2);
        for (int i = 0; i < 5; i++) send($urandom);
        repeat (4) tick();
        n_checks++; if (obs_q.size() != 1 || exp_q.size() != 1 || obs_q[0] !== exp_q[0]) begin
            n_err++; $display("FAIL rmid_rerun got n=%0d %h want 1 of %h", obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : 64'd0, (exp_q.size() > 0) ? exp_q[0] : 64'd0);
        end
        restart(5'd2);
        send(32'd1000); send(32'd5000); send(32'd9000);
        restart(5'd2);
        send(32'd10); send(32'd20); send(32'd30); send(32'd40); send(32'd50);
        repeat (4) tick();
        n_checks++; if (obs_q.size() != 1 || obs_q[0] !== {32'd35, 32'd40}) begin
            n_err++; $display("FAIL dis_rerun got n=%0d %h want 1 of %h", obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : 64'd0, {32'd35, 32'd40});
        end
    endtask

    task automatic test_random();
        logic [15:0] wc0;
        m_tready = 1'b1;
        for (int r = 0; r < 6; r++) begin
            restart(5'($urandom_range(0, 3)));
            wc0 = wc;
            for (int i = 0; i < 60; i++) begin
                if ($urandom_range(0, 3) == 0) tick();
                else begin
                    if ($urandom_range(0, 9) == 0) decim = 5'($urandom_range(0, 3));
                    send($urandom);
                end
            end
            repeat (6) tick();
            n_checks++; if (obs_q.size() != exp_q.size()) begin
                n_err++; $display("FAIL rand%0d_count got %0d want %0d", r, obs_q.size(), exp_q.size());
            end else begin
                for (int i = 0; i < exp_q.size(); i++) begin
                    n_checks++; if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL rand%0d_res%0d got %h want %h", r, i, obs_q[i], exp_q[i]); end
                end
            end
            n_checks++; if (wc !== 16'(wc0 + 16'(exp_q.size()))) begin
                n_err++; $display("FAIL rand%0d_wcount got %0d want %0d", r, wc, 16'(wc0 + 16'(exp_q.size())));
            end
        end
    endtask

    initial begin
        areset   = 1'b1;
        enable   = 1'b0;
        s_tvalid = 1'b0;
        s_tdata  = '0;
        decim    = '0;
        m_tready = 1'b1;
        model_reset();
        test_reset();
        test_ramp();
        test_floor();
        test_delta_wrap();
        test_back_pressure();
        test_reset_disable_mid();
        test_random();
        test_clamp_kchange();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
`default_nettype wire
